// File: rtl/param_seq_divider.sv
// param_seq_divider
//   Multi-cycle restoring divider that produces one quotient bit per clock.
//   Each operation can be unsigned or two's-complement (signed_mode, sampled
//   together with the operands). Valid/ready handshakes are used on both the
//   operand side and the result side. The unit flags divide-by-zero and the
//   signed overflow case (most-negative / -1).
//
// Parameters
//   WIDTH      operand/result width (>= 2)
//   SIGNED_EN  1: signed_mode honoured; 0: always unsigned, ovf tied low
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   in_valid / in_ready           operand handshake (ready only while idle)
//   signed_mode, dividend,        operands, latched on the accept edge
//   divisor
//   out_valid / out_ready         result handshake (valid held until ready)
//   quotient, remainder,          result; updated only on entry to DONE and
//   error, ovf                    retained after the handshake

module param_seq_divider #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error,
  output logic             ovf
);

  localparam int unsigned      CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;       // dividend magnitude, becomes quotient bit by bit
  logic [WIDTH-1:0] dvs;       // divisor magnitude
  logic [WIDTH-1:0] rem;       // partial remainder
  logic             sq;        // negate quotient in FIXUP
  logic             sr;        // negate remainder in FIXUP
  logic             ovf_pend;

  logic             eff_signed;
  logic             accept;
  logic             div_zero;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] rem_next;

  assign eff_signed = SIGNED_EN & signed_mode;
  assign accept     = in_valid & in_ready;
  assign div_zero   = (divisor == '0);

  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
    if (eff_signed && dividend[WIDTH-1]) dividend_mag = '0 - dividend;
    if (eff_signed && divisor[WIDTH-1])  divisor_mag  = '0 - divisor;
  end

  // The restored remainder is always below the divisor, so it fits in WIDTH
  // bits; only the shifted trial value needs the extra carry bit. When the
  // subtraction succeeds the true difference is below 2^WIDTH, so a
  // WIDTH-bit modular subtract gives the exact result.
  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    take     = (shifted >= {1'b0, dvs});
    rem_next = take ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = div_zero ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (cnt == LAST) state_next = S_FIXUP;
      S_FIXUP:  state_next = S_DONE;
      S_DONE:   if (out_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      sq        <= 1'b0;
      sr        <= 1'b0;
      ovf_pend  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      error     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            dvd      <= dividend_mag;
            dvs      <= divisor_mag;
            rem      <= '0;
            cnt      <= '0;
            sq       <= eff_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sr       <= eff_signed & dividend[WIDTH-1];
            ovf_pend <= eff_signed && (dividend == MOST_NEG) && (divisor == '1);
            if (div_zero) begin
              quotient  <= '1;
              remainder <= dividend;
              error     <= 1'b1;
              ovf       <= 1'b0;
            end
          end
        end
        S_DIVIDE: begin
          rem <= rem_next;
          dvd <= {dvd[WIDTH-2:0], take};
          cnt <= cnt + 1'b1;
        end
        S_FIXUP: begin
          quotient  <= sq ? ('0 - dvd) : dvd;
          remainder <= sr ? ('0 - rem) : rem;
          error     <= 1'b0;
          ovf       <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_divider.sv
// tb_param_seq_divider
//   Directed table of WIDTH=8 operations with hand-computed results, hand
//   sequences for back-pressure and mid-operation reset, and a short sweep
//   on WIDTH=8 and WIDTH=16 instances against a behavioural reference.
//   Latency is counted with the accept edge as clock 1: a divide-by-zero
//   result is visible right after the accept edge (1), a normal one after
//   the edge WIDTH+1 clocks later (WIDTH+2).

module tb_param_seq_divider;

  logic clk;
  logic reset_n;

  logic        iv8, ir8, sm8, ov8, ordy8, e8, o8;
  logic [7:0]  dd8, ds8, q8, r8;
  logic        iv16, ir16, sm16, ov16, ordy16, e16, o16;
  logic [15:0] dd16, ds16, q16, r16;

  int checks = 0;
  int errors = 0;

  param_seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) u8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
    .signed_mode(sm8), .dividend(dd8), .divisor(ds8), .out_valid(ov8),
    .out_ready(ordy8), .quotient(q8), .remainder(r8), .error(e8), .ovf(o8)
  );

  param_seq_divider #(.WIDTH(16), .SIGNED_EN(1'b1)) u16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
    .signed_mode(sm16), .dividend(dd16), .divisor(ds16), .out_valid(ov16),
    .out_ready(ordy16), .quotient(q16), .remainder(r16), .error(e16), .ovf(o16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         s;
    logic [7:0] a, b;
    logic [7:0] q, r;
    bit         e, o;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input int w, input bit s, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output bit e, output bit o);
    longint sa, sb, qq, rr, mask;
    mask = (longint'(1) << w) - 1;
    e = 1'b0;
    o = 1'b0;
    if (b == 16'h0) begin
      q = 16'(mask);
      r = a;
      e = 1'b1;
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[w-1]) sa = sa - (longint'(1) << w);
      if (s && b[w-1]) sb = sb - (longint'(1) << w);
      qq = sa / sb;
      rr = sa % sb;
      o  = s && (sa == -(longint'(1) << (w - 1))) && (sb == -1);
      q  = 16'(qq & mask);
      r  = 16'(rr & mask);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ir8"}, 32'(ir8), 32'd1);
    chk({tag, "_ov8"}, 32'(ov8), 32'd0);
    chk({tag, "_q8"}, 32'(q8), 32'd0);
    chk({tag, "_r8"}, 32'(r8), 32'd0);
    chk({tag, "_e8"}, 32'(e8), 32'd0);
    chk({tag, "_o8"}, 32'(o8), 32'd0);
    chk({tag, "_ir16"}, 32'(ir16), 32'd1);
    chk({tag, "_ov16"}, 32'(ov16), 32'd0);
    chk({tag, "_q16"}, 32'(q16), 32'd0);
  endtask

  // One complete operation on the selected instance; operands are scrambled
  // after the accept edge to show they are not re-sampled.
  task automatic run_op(input bit w16, input bit s, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r,
                        output bit e, output bit o, output int lat);
    @(negedge clk);
    chk(w16 ? "pre_in_ready16" : "pre_in_ready8", 32'(w16 ? ir16 : ir8), 32'd1);
    if (w16) begin
      sm16 = s; dd16 = a; ds16 = b; iv16 = 1'b1;
    end else begin
      sm8 = s; dd8 = a[7:0]; ds8 = b[7:0]; iv8 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    iv8  = 1'b0;
    iv16 = 1'b0;
    dd8  = 8'($urandom);  ds8  = 8'($urandom);  sm8  = ~sm8;
    dd16 = 16'($urandom); ds16 = 16'($urandom); sm16 = ~sm16;
    lat = 1;
    while (!(w16 ? ov16 : ov8) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (w16) begin
      q = q16; r = r16; e = e16; o = o16;
    end else begin
      q = {8'h00, q8}; r = {8'h00, r8}; e = e8; o = o8;
    end
    if (w16) ordy16 = 1'b1; else ordy8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy8  = 1'b0;
    ordy16 = 1'b0;
    chk(w16 ? "post_in_ready16" : "post_in_ready8", 32'(w16 ? ir16 : ir8), 32'd1);
    chk(w16 ? "post_out_valid16" : "post_out_valid8", 32'(w16 ? ov16 : ov8), 32'd0);
  endtask

  logic [15:0] gq, gr, mq, mr, ra, rb;
  bit          ge, go, me, mo, rs, rw;
  int          glat;

  initial begin
    vecs[0]  = '{s:1'b0, a:8'd100, b:8'd7,   q:8'd14,  r:8'd2,   e:1'b0, o:1'b0, lat:10};
    vecs[1]  = '{s:1'b1, a:8'h9C,  b:8'h07,  q:8'hF2,  r:8'hFE,  e:1'b0, o:1'b0, lat:10};
    vecs[2]  = '{s:1'b1, a:8'h64,  b:8'hF9,  q:8'hF2,  r:8'h02,  e:1'b0, o:1'b0, lat:10};
    vecs[3]  = '{s:1'b0, a:8'h5A,  b:8'h00,  q:8'hFF,  r:8'h5A,  e:1'b1, o:1'b0, lat:1};
    vecs[4]  = '{s:1'b1, a:8'h80,  b:8'hFF,  q:8'h80,  r:8'h00,  e:1'b0, o:1'b1, lat:10};
    vecs[5]  = '{s:1'b0, a:8'h80,  b:8'hFF,  q:8'h00,  r:8'h80,  e:1'b0, o:1'b0, lat:10};
    vecs[6]  = '{s:1'b0, a:8'd255, b:8'd16,  q:8'd15,  r:8'd15,  e:1'b0, o:1'b0, lat:10};
    vecs[7]  = '{s:1'b1, a:8'hA5,  b:8'h00,  q:8'hFF,  r:8'hA5,  e:1'b1, o:1'b0, lat:1};
    vecs[8]  = '{s:1'b1, a:8'h80,  b:8'h01,  q:8'h80,  r:8'h00,  e:1'b0, o:1'b0, lat:10};
    vecs[9]  = '{s:1'b0, a:8'd5,   b:8'd9,   q:8'd0,   r:8'd5,   e:1'b0, o:1'b0, lat:10};
    vecs[10] = '{s:1'b1, a:8'hF9,  b:8'hFE,  q:8'h03,  r:8'hFF,  e:1'b0, o:1'b0, lat:10};
    vecs[11] = '{s:1'b0, a:8'd200, b:8'd1,   q:8'd200, r:8'd0,   e:1'b0, o:1'b0, lat:10};

    reset_n = 1'b0;
    iv8 = 1'b0; sm8 = 1'b0; dd8 = '0; ds8 = '0; ordy8 = 1'b0;
    iv16 = 1'b0; sm16 = 1'b0; dd16 = '0; ds16 = '0; ordy16 = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, vecs[i].s, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, gq, gr, ge, go, glat);
      chk($sformatf("vec%0d_q", i), 32'(gq), 32'(vecs[i].q));
      chk($sformatf("vec%0d_r", i), 32'(gr), 32'(vecs[i].r));
      chk($sformatf("vec%0d_err", i), 32'(ge), 32'(vecs[i].e));
      chk($sformatf("vec%0d_ovf", i), 32'(go), 32'(vecs[i].o));
      chk($sformatf("vec%0d_lat", i), 32'(glat), 32'(vecs[i].lat));
    end

    // Back-pressure: result held, busy, new operands ignored
    @(negedge clk);
    sm8 = 1'b0; dd8 = 8'd100; ds8 = 8'd7; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    glat = 1;
    while (!ov8 && glat < 40) begin
      @(negedge clk);
      glat++;
    end
    chk("hold_lat", 32'(glat), 32'd10);
    for (int k = 0; k < 5; k++) begin
      iv8 = 1'b1; dd8 = 8'd3; ds8 = 8'd1;
      chk($sformatf("hold%0d_ov", k), 32'(ov8), 32'd1);
      chk($sformatf("hold%0d_ir", k), 32'(ir8), 32'd0);
      chk($sformatf("hold%0d_q", k), 32'(q8), 32'd14);
      chk($sformatf("hold%0d_r", k), 32'(r8), 32'd2);
      @(negedge clk);
    end
    iv8 = 1'b0;
    ordy8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy8 = 1'b0;
    chk("hold_rel_ov", 32'(ov8), 32'd0);
    chk("hold_rel_ir", 32'(ir8), 32'd1);
    chk("hold_retain_q", 32'(q8), 32'd14);
    chk("hold_retain_r", 32'(r8), 32'd2);
    repeat (12) @(negedge clk);
    chk("hold_no_stray_ov", 32'(ov8), 32'd0);

    // Reset in the 4th DIVIDE cycle
    sm8 = 1'b0; dd8 = 8'd100; ds8 = 8'd7; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b0, 1'b0, 16'd255, 16'd16, gq, gr, ge, go, glat);
    chk("after_reset_q", 32'(gq), 32'd15);
    chk("after_reset_r", 32'(gr), 32'd15);
    chk("after_reset_err", 32'(ge), 32'd0);
    chk("after_reset_lat", 32'(glat), 32'd10);

    // Sweep on both widths against the reference
    for (int i = 0; i < 24; i++) begin
      rw = i[0];
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 7 == 3) rb = '0;
      if (i == 5) begin rs = 1'b1; ra = 16'h8000; rb = 16'hFFFF; end
      if (!rw) begin ra[15:8] = '0; rb[15:8] = '0; end
      if (i % 5 == 4 && rb != '0) rb = rw ? 16'h0003 : 16'h00FD;
      model(rw ? 16 : 8, rs, ra, rb, mq, mr, me, mo);
      run_op(rw, rs, ra, rb, gq, gr, ge, go, glat);
      chk($sformatf("sweep%0d_q", i), 32'(gq), 32'(mq));
      chk($sformatf("sweep%0d_r", i), 32'(gr), 32'(mr));
      chk($sformatf("sweep%0d_err", i), 32'(ge), 32'(me));
      chk($sformatf("sweep%0d_ovf", i), 32'(go), 32'(mo));
      chk($sformatf("sweep%0d_lat", i), 32'(glat), me ? 32'd1 : (rw ? 32'd18 : 32'd10));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
